register_value_uart: RTL

REGISTER_VALUE_UART -- requirements
Module: register_value_uart

---
 rtl/register_value_uart_pkg.sv | 24 ++
 rtl/register_value_uart_tx_byte.sv | 113 +++++++++++
 rtl/register_value_uart.sv | 104 ++++++++++
 3 files changed

// File: rtl/register_value_uart_pkg.sv
// rtl/register_value_uart_pkg.sv - shared state enum, ASCII constants and defaults
// UART_PARITY_EN adds the PARITY state to the serializer state set.
package register_value_uart_pkg;

  localparam int DEFAULT_REGISTER_WIDTH = 16;
  localparam int DEFAULT_CLOCKS_PER_BIT = 434;

  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return ASCII_ZERO + {4'd0, nibble};
    return ASCII_UPPER_A + {4'd0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/register_value_uart_tx_byte.sv
// rtl/register_value_uart_tx_byte.sv - 8N1 byte serializer with start/done handshake
// UART_PARITY_EN inserts an even-parity bit after bit 7.
module uart_tx_byte
  import register_value_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              txd_q, txd_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  // done is decoded from registers only so the caller can chain the next byte combinationally
  assign done_o    = (state_q == ST_STOP) && baud_last;
  assign txd_o     = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    txd_d   = txd_q;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (start_i) begin
          state_d = ST_START;
          data_d  = data_i;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          txd_d   = data_q[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = ^data_q;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = data_q[bit_d];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          if (start_i) begin
            state_d = ST_START;
            data_d  = data_i;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/register_value_uart.sv
// rtl/register_value_uart.sv - reports register changes as hex text lines over a UART
// UART_PARITY_EN (in the serializer) switches to 11-bit even-parity characters.
module register_value_uart
  import register_value_uart_pkg::*;
#(
  parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      txd,
  output logic                      busy,
  output logic [7:0]                lineCount
);

  localparam int NUM_DIGITS = REGISTER_WIDTH / 4;
  localparam int NUM_CHARS  = NUM_DIGITS + 2;
  localparam int CHAR_W     = $clog2(NUM_CHARS);

  logic                      busy_q, busy_d;
  logic [7:0]                line_count_q, line_count_d;
  logic [REGISTER_WIDTH-1:0] last_sent_q, last_sent_d;
  logic [REGISTER_WIDTH-1:0] snapshot_q, snapshot_d;
  logic [CHAR_W-1:0]         char_q, char_d;
  logic [CHAR_W-1:0]         char_next;
  logic                      change, last_char;
  logic                      tx_start, tx_done;
  logic [7:0]                tx_data;

  // Character idx of the line for value: hex digits MS nibble first, then CR, LF.
  function automatic logic [7:0] char_at(input logic [REGISTER_WIDTH-1:0] value,
                                         input logic [CHAR_W-1:0]         idx);
    if (int'(idx) == NUM_DIGITS) return ASCII_CR;
    if (int'(idx) > NUM_DIGITS) return ASCII_LF;
    return hex_ascii(value[(REGISTER_WIDTH - 4) - 4 * int'(idx) +: 4]);
  endfunction

  assign change    = (register1Value != last_sent_q);
  assign last_char = (char_q == CHAR_W'(NUM_CHARS - 1));
  assign char_next = char_q + 1'b1;

  always_comb begin
    busy_d       = busy_q;
    line_count_d = line_count_q;
    last_sent_d  = last_sent_q;
    snapshot_d   = snapshot_q;
    char_d       = char_q;
    tx_start     = 1'b0;
    tx_data      = 8'd0;
    if (!busy_q) begin
      if (change) begin
        busy_d      = 1'b1;
        snapshot_d  = register1Value;
        last_sent_d = register1Value;
        char_d      = '0;
        tx_start    = 1'b1;
        tx_data     = char_at(register1Value, {CHAR_W{1'b0}});
      end
    end else if (tx_done) begin
      // next character is handed over on the stop bit's last cycle to keep the line gapless
      if (last_char) begin
        busy_d       = 1'b0;
        line_count_d = line_count_q + 8'd1;
        char_d       = '0;
      end else begin
        char_d   = char_next;
        tx_start = 1'b1;
        tx_data  = char_at(snapshot_q, char_next);
      end
    end
  end

  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      busy_q       <= 1'b0;
      line_count_q <= 8'd0;
      last_sent_q  <= '0;
      snapshot_q   <= '0;
      char_q       <= '0;
    end else begin
      busy_q       <= busy_d;
      line_count_q <= line_count_d;
      last_sent_q  <= last_sent_d;
      snapshot_q   <= snapshot_d;
      char_q       <= char_d;
    end
  end

  uart_tx_byte #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_tx_byte (
    .clk_i  (clock),
    .rst_ni (isReset),
    .start_i(tx_start),
    .data_i (tx_data),
    .txd_o  (txd),
    .done_o (tx_done)
  );

  assign busy      = busy_q;
  assign lineCount = line_count_q;

endmodule
